// File: rtl/mips_cpu_harvard.sv
// rtl/mips_cpu_harvard.sv - single-cycle MIPS I subset core, Harvard buses, one branch delay slot
// Optional HI/LO multiply/divide unit enabled by defining MULT_DIV_EN.
module mips_cpu_harvard #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   input  logic        clk_enable,
   output logic [31:0] instr_address,
   input  logic [31:0] instr_readdata,
   output logic [31:0] data_address,
   output logic        data_write,
   output logic        data_read,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata
);

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ     = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09,
                          OP_SLTI    = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                          OP_ORI     = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                          OP_LW      = 6'h23, OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_JR  = 6'h08,
                          FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO  = 6'h12, FN_MTLO = 6'h13,
                          FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B,
                          FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25,
                          FN_XOR  = 6'h26, FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;

   logic [31:0] pc_q, pc_plus4, next_pc;
   logic [31:0] branch_target_q;
   logic        branch_pending_q;
   logic        active_q;
   logic [31:0] gpr [0:31];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val, imm_sext, imm_zext, mem_addr;

   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        take_branch;
   logic [31:0] take_target;
   logic        is_lw, is_sw;

   assign opcode   = instr_readdata[31:26];
   assign rs       = instr_readdata[25:21];
   assign rt       = instr_readdata[20:16];
   assign rd       = instr_readdata[15:11];
   assign shamt    = instr_readdata[10:6];
   assign funct    = instr_readdata[5:0];
   assign imm      = instr_readdata[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};
   assign rs_val   = gpr[rs];
   assign rt_val   = gpr[rt];
   assign mem_addr = rs_val + imm_sext;

   assign pc_plus4 = pc_q + 32'd4;
   // The delay-slot instruction executes now; a branch taken last cycle redirects after it.
   assign next_pc  = branch_pending_q ? branch_target_q : pc_plus4;

   assign instr_address  = pc_q;
   assign active         = active_q;
   assign register_v0    = gpr[2];
   assign data_address   = mem_addr;
   assign data_writedata = rt_val;
   assign data_read      = reset & active_q & is_lw;
   assign data_write     = reset & active_q & clk_enable & is_sw;

`ifdef MULT_DIV_EN
   logic [31:0] hi_q, lo_q, hi_next, lo_next;
   logic        hilo_wr;
   logic [63:0] prod_s, prod_u;
   logic signed [31:0] rs_s, rt_s;

   assign rs_s   = rs_val;
   assign rt_s   = rt_val;
   assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
`endif

   always_comb begin
      wr_en       = 1'b0;
      wr_addr     = rd;
      wr_data     = 32'h0;
      take_branch = 1'b0;
      take_target = 32'h0;
      is_lw       = 1'b0;
      is_sw       = 1'b0;
`ifdef MULT_DIV_EN
      hilo_wr     = 1'b0;
      hi_next     = hi_q;
      lo_next     = lo_q;
`endif
      case (opcode)
         OP_SPECIAL: begin
            wr_en = 1'b1;
            case (funct)
               FN_SLL:  wr_data = rt_val << shamt;
               FN_SRL:  wr_data = rt_val >> shamt;
               FN_SRA:  wr_data = $unsigned($signed(rt_val) >>> shamt);
               FN_ADDU: wr_data = rs_val + rt_val;
               FN_SUBU: wr_data = rs_val - rt_val;
               FN_AND:  wr_data = rs_val & rt_val;
               FN_OR:   wr_data = rs_val | rt_val;
               FN_XOR:  wr_data = rs_val ^ rt_val;
               FN_SLT:  wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
               FN_SLTU: wr_data = {31'h0, rs_val < rt_val};
               FN_JR: begin
                  wr_en       = 1'b0;
                  take_branch = 1'b1;
                  take_target = rs_val;
               end
`ifdef MULT_DIV_EN
               FN_MFHI: wr_data = hi_q;
               FN_MFLO: wr_data = lo_q;
               FN_MTHI: begin wr_en = 1'b0; hilo_wr = 1'b1; hi_next = rs_val; end
               FN_MTLO: begin wr_en = 1'b0; hilo_wr = 1'b1; lo_next = rs_val; end
               FN_MULT: begin wr_en = 1'b0; hilo_wr = 1'b1; {hi_next, lo_next} = prod_s; end
               FN_MULTU: begin wr_en = 1'b0; hilo_wr = 1'b1; {hi_next, lo_next} = prod_u; end
               FN_DIV: begin
                  wr_en = 1'b0;
                  // A zero divisor leaves HI/LO untouched.
                  if (rt_val != 32'h0) begin
                     hilo_wr = 1'b1;
                     lo_next = $unsigned(rs_s / rt_s);
                     hi_next = $unsigned(rs_s % rt_s);
                  end
               end
               FN_DIVU: begin
                  wr_en = 1'b0;
                  if (rt_val != 32'h0) begin
                     hilo_wr = 1'b1;
                     lo_next = rs_val / rt_val;
                     hi_next = rs_val % rt_val;
                  end
               end
`endif
               default: wr_en = 1'b0;
            endcase
         end
         OP_J: begin
            take_branch = 1'b1;
            take_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
         end
         OP_JAL: begin
            take_branch = 1'b1;
            take_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
            wr_en       = 1'b1;
            wr_addr     = 5'd31;
            wr_data     = pc_q + 32'd8;
         end
         OP_BEQ, OP_BNE: begin
            take_branch = (rs_val == rt_val) ^ (opcode == OP_BNE);
            take_target = pc_plus4 + {imm_sext[29:0], 2'b00};
         end
         OP_ADDIU: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + imm_sext; end
         OP_SLTI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'h0, $signed(rs_val) < $signed(imm_sext)}; end
         OP_SLTIU: begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'h0, rs_val < imm_sext}; end
         OP_ANDI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & imm_zext; end
         OP_ORI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | imm_zext; end
         OP_XORI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ imm_zext; end
         OP_LUI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = {imm, 16'h0000}; end
         OP_LW: begin
            is_lw   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = rt;
            wr_data = data_readdata;
         end
         OP_SW:    is_sw = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q             <= RESET_VECTOR;
         branch_pending_q <= 1'b0;
         branch_target_q  <= 32'h0;
         active_q         <= 1'b1;
         for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
      end else if (clk_enable && active_q) begin
         pc_q             <= next_pc;
         active_q         <= (next_pc != 32'h0);
         branch_pending_q <= take_branch;
         branch_target_q  <= take_target;
         if (wr_en && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
      end
   end

`ifdef MULT_DIV_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= 32'h0;
         lo_q <= 32'h0;
      end else if (clk_enable && active_q && hilo_wr) begin
         hi_q <= hi_next;
         lo_q <= lo_next;
      end
   end
`endif

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb/tb_mips_cpu_harvard.sv - directed scoreboard bench for mips_cpu_harvard
module tb_mips_cpu_harvard;

   logic        clk = 1'b0;
   logic        reset;
   logic        active;
   logic [31:0] register_v0;
   logic        clk_enable;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;

   logic [31:0] imem [0:31];
   logic [31:0] dmem [0:15];

   int errors = 0;
   int checks = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

`ifdef MULT_DIV_EN
   localparam logic [31:0] EXP_MFHI = 32'h00000001;
   localparam logic [31:0] EXP_MFLO = 32'h00000000;
`else
   localparam logic [31:0] EXP_MFHI = 32'h00001234;
   localparam logic [31:0] EXP_MFLO = 32'h00001234;
`endif

   mips_cpu_harvard #(.RESET_VECTOR(32'hBFC00000)) dut (
      .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
      .clk_enable(clk_enable), .instr_address(instr_address),
      .instr_readdata(instr_readdata), .data_address(data_address),
      .data_write(data_write), .data_read(data_read),
      .data_writedata(data_writedata), .data_readdata(data_readdata)
   );

   always #5 clk = ~clk;

   assign instr_readdata = ((instr_address & 32'hFFFFFF80) == 32'hBFC00000) ?
                           imem[instr_address[6:2]] : 32'h0;
   assign data_readdata  = dmem[data_address[5:2]];

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
      end else if (data_write) begin
         dmem[data_address[5:2]] <= data_writedata;
      end
   end

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      string t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queue the expected architectural state, retire one instruction, then compare.
   task automatic run(input string tag, input logic [31:0] pc_exp, input logic [31:0] v0_exp);
      expect_val({tag, "_pc"}, pc_exp);
      expect_val({tag, "_v0"}, v0_exp);
      step();
      check(instr_address);
      check(register_v0);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 32; i++) imem[i] = 32'h0;
   endtask

   initial begin
      reset = 1'b0;
      clk_enable = 1'b1;

      // Program A: LUI $2,1; JR $0; ADDIU $0,$0,0
      clear_imem();
      imem[0] = 32'h3C020001;
      imem[1] = 32'h00000008;
      imem[2] = 32'h24000000;
      step();
      step();
      expect_val("rst_pc", 32'hBFC00000);     check(instr_address);
      expect_val("rst_v0", 32'h0);            check(register_v0);
      expect_val("rst_active", 32'h1);        check({31'h0, active});
      expect_val("rst_dwrite", 32'h0);        check({31'h0, data_write});
      expect_val("rst_dread", 32'h0);         check({31'h0, data_read});
      reset = 1'b1;
      run("a_lui", 32'hBFC00004, 32'h00010000);
      run("a_jr", 32'hBFC00008, 32'h00010000);
      run("a_slot", 32'h00000000, 32'h00010000);
      expect_val("halt_active", 32'h0);       check({31'h0, active});
      for (int i = 0; i < 3; i++) begin
         run("halted", 32'h00000000, 32'h00010000);
         expect_val("halted_active", 32'h0);  check({31'h0, active});
         expect_val("halted_dwrite", 32'h0);  check({31'h0, data_write});
      end

      // Reset while halted, off the clock edge.
      #2 reset = 1'b0;
      #1;
      expect_val("rst_halt_pc", 32'hBFC00000); check(instr_address);
      expect_val("rst_halt_v0", 32'h0);        check(register_v0);
      expect_val("rst_halt_act", 32'h1);       check({31'h0, active});

      // Program B: load/store, wrap, branch/jump delay slots, compares and shifts.
      clear_imem();
      imem[0]  = 32'h2402FFFF;
      imem[1]  = 32'hAC020010;
      imem[2]  = 32'h8C030010;
      imem[3]  = 32'h24620001;
      imem[4]  = 32'h00601021;
      imem[5]  = 32'h24020000;
      imem[6]  = 32'h10000002;
      imem[7]  = 32'h24420005;
      imem[8]  = 32'h24020077;
      imem[9]  = 32'h3C048000;
      imem[10] = 32'h0080102A;
      imem[11] = 32'h0080102B;
      imem[12] = 32'h00041103;
      imem[13] = 32'h00041102;
      imem[14] = 32'h34028001;
      imem[15] = 32'h0FF00012;
      imem[16] = 32'h03E01021;
      imem[17] = 32'h24020077;
      imem[18] = 32'h24020007;
      imem[19] = 32'h00000008;
      imem[20] = 32'h00000000;
      step();
      #3 reset = 1'b1;
      run("b_addiu", 32'hBFC00004, 32'hFFFFFFFF);
      expect_val("sw_dwrite", 32'h1);          check({31'h0, data_write});
      expect_val("sw_daddr", 32'h00000010);    check(data_address);
      expect_val("sw_wdata", 32'hFFFFFFFF);    check(data_writedata);
      expect_val("sw_dread", 32'h0);           check({31'h0, data_read});
      clk_enable = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         expect_val("hold_dwrite", 32'h0);     check({31'h0, data_write});
         run("hold", 32'hBFC00004, 32'hFFFFFFFF);
         expect_val("hold_mem", 32'h0);        check(dmem[4]);
      end
      clk_enable = 1'b1;
      run("b_sw", 32'hBFC00008, 32'hFFFFFFFF);
      expect_val("sw_mem", 32'hFFFFFFFF);      check(dmem[4]);
      expect_val("lw_dread", 32'h1);           check({31'h0, data_read});
      expect_val("lw_dwrite", 32'h0);          check({31'h0, data_write});
      run("b_lw", 32'hBFC0000C, 32'hFFFFFFFF);
      run("b_wrap", 32'hBFC00010, 32'h00000000);
      run("b_lw_rd", 32'hBFC00014, 32'hFFFFFFFF);
      run("b_clr", 32'hBFC00018, 32'h00000000);
      run("b_beq", 32'hBFC0001C, 32'h00000000);
      run("b_beq_slot", 32'hBFC00024, 32'h00000005);
      run("b_lui", 32'hBFC00028, 32'h00000005);
      run("b_slt", 32'hBFC0002C, 32'h00000001);
      run("b_sltu", 32'hBFC00030, 32'h00000000);
      run("b_sra", 32'hBFC00034, 32'hF8000000);
      run("b_srl", 32'hBFC00038, 32'h08000000);
      run("b_ori", 32'hBFC0003C, 32'h00008001);
      run("b_jal", 32'hBFC00040, 32'h00008001);
      run("b_jal_slot", 32'hBFC00048, 32'hBFC00044);
      run("b_after_jal", 32'hBFC0004C, 32'h00000007);
      run("b_jr", 32'hBFC00050, 32'h00000007);

      // Reset inside the JR delay slot; the pending jump to 0 must be dropped.
      #2 reset = 1'b0;
      #1;
      expect_val("rst_slot_pc", 32'hBFC00000); check(instr_address);
      expect_val("rst_slot_v0", 32'h0);        check(register_v0);
      expect_val("rst_slot_act", 32'h1);       check({31'h0, active});

      // Program C: HI/LO access (NOP when the unit is absent).
      clear_imem();
      imem[0] = 32'h24021234;
      imem[1] = 32'h3C050001;
      imem[2] = 32'h00A50019;
      imem[3] = 32'h00001010;
      imem[4] = 32'h00001012;
      imem[5] = 32'h00000008;
      imem[6] = 32'h00000000;
      #3 reset = 1'b1;
      run("c_addiu", 32'hBFC00004, 32'h00001234);
      run("c_lui", 32'hBFC00008, 32'h00001234);
      run("c_multu", 32'hBFC0000C, 32'h00001234);
      run("c_mfhi", 32'hBFC00010, EXP_MFHI);
      run("c_mflo", 32'hBFC00014, EXP_MFLO);
      run("c_jr", 32'hBFC00018, EXP_MFLO);
      run("c_slot", 32'h00000000, EXP_MFLO);
      expect_val("c_halt_active", 32'h0);      check({31'h0, active});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
